// File: rtl/wb_write_queue.sv
// Writeback queue in front of the register file write port.
// Buffers up to DEPTH results while the port is stalled. Issues at most one
// write per cycle. Decode can look up pending results by register index.
module wb_write_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4,
  parameter int PC_IDX = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDR_W-1:0]           in_dest,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        wb_stall,
  input  logic                        flush,
  output logic                        wb_en,
  output logic [ADDR_W-1:0]           wb_dest,
  output logic [DATA_W-1:0]           wb_data,
  input  logic [ADDR_W-1:0]           src1,
  input  logic [ADDR_W-1:0]           src2,
  output logic                        hit1,
  output logic                        hit2,
  output logic [DATA_W-1:0]           fwd1,
  output logic [DATA_W-1:0]           fwd2,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        pc_drop
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_A     = ADDR_W'(PC_IDX);

  logic [DEPTH-1:0][ADDR_W-1:0] dest_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             vld_q;
  logic [PW-1:0]                wptr, rptr, idx;
  logic                         full, empty, enq_fire, enq_store, deq;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  // The PC is not held in the file, so a write to it is taken but never stored.
  assign enq_fire  = in_valid && in_ready && !flush;
  assign enq_store = enq_fire && (in_dest != PC_A);
  assign wb_en     = !empty && !wb_stall;
  assign deq       = wb_en;
  assign wb_dest   = empty ? '0 : dest_q[rptr];
  assign wb_data   = empty ? '0 : data_q[rptr];

  // Queue state. A flush still lets the head write go out this cycle, because
  // wb_en comes from the state before the flush. It then empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_q  <= '0;
      data_q  <= '0;
      vld_q   <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      pc_drop <= 1'b0;
    end else begin
      pc_drop <= enq_fire && (in_dest == PC_A);
      if (flush) begin
        vld_q <= '0;
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (enq_store) begin
          dest_q[wptr] <= in_dest;
          data_q[wptr] <= in_data;
          vld_q[wptr]  <= 1'b1;
          wptr         <= wptr + 1'b1;
        end
        if (deq) begin
          vld_q[rptr] <= 1'b0;
          rptr        <= rptr + 1'b1;
        end
        case ({enq_store, deq})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Forwarding lookup. Entries are visited from oldest (rptr) to newest, so
  // the last match found is the newest one. The head still hits while it is
  // being written.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    fwd1 = '0;
    fwd2 = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr + PW'(k);
      if (vld_q[idx] && dest_q[idx] == src1 && src1 != PC_A) begin
        hit1 = 1'b1;
        fwd1 = data_q[idx];
      end
      if (vld_q[idx] && dest_q[idx] == src2 && src2 != PC_A) begin
        hit2 = 1'b1;
        fwd2 = data_q[idx];
      end
    end
  end
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue.
// The first part is a table of per-cycle vectors.
// The second part is hand-written sequences for the full, wrap and async reset cases.
module tb_wb_write_queue;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, wb_stall = 1'b0, flush = 1'b0;
  logic [3:0]  in_dest = '0, src1 = '0, src2 = '0, wb_dest;
  logic [31:0] in_data = '0, wb_data, fwd1, fwd2;
  logic        wb_en, hit1, hit2, pc_drop;
  logic [2:0]  count;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  wb_write_queue #(.DATA_W(32), .ADDR_W(4), .DEPTH(4), .PC_IDX(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_data(in_data), .wb_stall(wb_stall), .flush(flush),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .src1(src1), .src2(src2), .hit1(hit1), .hit2(hit2),
    .fwd1(fwd1), .fwd2(fwd2), .count(count), .pc_drop(pc_drop)
  );

  typedef struct {
    logic iv; logic [3:0] id; logic [31:0] idat; logic st; logic fl;
    logic [3:0] s1; logic [3:0] s2;
    logic rdy; logic en; logic [3:0] dst; logic [31:0] dat;
    logic h1; logic [31:0] f1; logic h2; logic [31:0] f2;
    logic [2:0] cnt; logic pc;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                iv    id     idat      st    fl    s1     s2     rdy   en    dst    dat       h1    f1        h2    f2        cnt   pc
    tbl[0]  = '{1'b0, 4'd0,  32'h00, 1'b0, 1'b0, 4'd0,  4'd0,  1'b1, 1'b0, 4'd0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h00, 3'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'd3,  32'hAA, 1'b0, 1'b0, 4'd0,  4'd0,  1'b1, 1'b0, 4'd0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h00, 3'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'd0,  32'h00, 1'b0, 1'b0, 4'd3,  4'd0,  1'b1, 1'b1, 4'd3, 32'hAA, 1'b1, 32'hAA, 1'b0, 32'h00, 3'd1, 1'b0};
    tbl[3]  = '{1'b0, 4'd0,  32'h00, 1'b0, 1'b0, 4'd3,  4'd0,  1'b1, 1'b0, 4'd0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h00, 3'd0, 1'b0};
    tbl[4]  = '{1'b1, 4'd7,  32'h11, 1'b1, 1'b0, 4'd0,  4'd0,  1'b1, 1'b0, 4'd0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h00, 3'd0, 1'b0};
    tbl[5]  = '{1'b1, 4'd7,  32'h22, 1'b1, 1'b0, 4'd7,  4'd0,  1'b1, 1'b0, 4'd7, 32'h11, 1'b1, 32'h11, 1'b0, 32'h00, 3'd1, 1'b0};
    tbl[6]  = '{1'b0, 4'd0,  32'h00, 1'b1, 1'b0, 4'd7,  4'd2,  1'b1, 1'b0, 4'd7, 32'h11, 1'b1, 32'h22, 1'b0, 32'h00, 3'd2, 1'b0};
    tbl[7]  = '{1'b1, 4'd15, 32'h55, 1'b1, 1'b0, 4'd15, 4'd7,  1'b1, 1'b0, 4'd7, 32'h11, 1'b0, 32'h00, 1'b1, 32'h22, 3'd2, 1'b0};
    tbl[8]  = '{1'b0, 4'd0,  32'h00, 1'b1, 1'b0, 4'd15, 4'd0,  1'b1, 1'b0, 4'd7, 32'h11, 1'b0, 32'h00, 1'b0, 32'h00, 3'd2, 1'b1};
    tbl[9]  = '{1'b0, 4'd0,  32'h00, 1'b1, 1'b0, 4'd0,  4'd0,  1'b1, 1'b0, 4'd7, 32'h11, 1'b0, 32'h00, 1'b0, 32'h00, 3'd2, 1'b0};
    tbl[10] = '{1'b1, 4'd9,  32'h33, 1'b1, 1'b0, 4'd9,  4'd0,  1'b1, 1'b0, 4'd7, 32'h11, 1'b0, 32'h00, 1'b0, 32'h00, 3'd2, 1'b0};
    tbl[11] = '{1'b1, 4'd10, 32'h44, 1'b1, 1'b1, 4'd9,  4'd7,  1'b1, 1'b0, 4'd7, 32'h11, 1'b1, 32'h33, 1'b1, 32'h22, 3'd3, 1'b0};
    tbl[12] = '{1'b0, 4'd0,  32'h00, 1'b0, 1'b0, 4'd10, 4'd7,  1'b1, 1'b0, 4'd0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h00, 3'd0, 1'b0};
    tbl[13] = '{1'b1, 4'd2,  32'h12, 1'b0, 1'b0, 4'd0,  4'd0,  1'b1, 1'b0, 4'd0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h00, 3'd0, 1'b0};
    tbl[14] = '{1'b0, 4'd0,  32'h00, 1'b0, 1'b1, 4'd2,  4'd0,  1'b1, 1'b1, 4'd2, 32'h12, 1'b1, 32'h12, 1'b0, 32'h00, 3'd1, 1'b0};
    tbl[15] = '{1'b0, 4'd0,  32'h00, 1'b0, 1'b0, 4'd2,  4'd0,  1'b1, 1'b0, 4'd0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h00, 3'd0, 1'b0};
    tbl[16] = '{1'b1, 4'd15, 32'h55, 1'b0, 1'b0, 4'd15, 4'd0,  1'b1, 1'b0, 4'd0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h00, 3'd0, 1'b0};
    tbl[17] = '{1'b0, 4'd0,  32'h00, 1'b0, 1'b0, 4'd15, 4'd0,  1'b1, 1'b0, 4'd0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h00, 3'd0, 1'b1};
    tbl[18] = '{1'b0, 4'd0,  32'h00, 1'b0, 1'b0, 4'd0,  4'd0,  1'b1, 1'b0, 4'd0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h00, 3'd0, 1'b0};

    // Reset state
    #2;
    chk("rst wb_en", 32'(wb_en), 0);
    chk("rst count", 32'(count), 0);
    chk("rst pc_drop", 32'(pc_drop), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Table: apply the inputs, check the outputs before the edge, then clock
    foreach (tbl[i]) begin
      in_valid = tbl[i].iv; in_dest = tbl[i].id; in_data = tbl[i].idat;
      wb_stall = tbl[i].st; flush = tbl[i].fl; src1 = tbl[i].s1; src2 = tbl[i].s2;
      #1;
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d wb_en", i),    32'(wb_en),    32'(tbl[i].en));
      chk($sformatf("row%0d wb_dest", i),  32'(wb_dest),  32'(tbl[i].dst));
      chk($sformatf("row%0d wb_data", i),  wb_data,       tbl[i].dat);
      chk($sformatf("row%0d hit1", i),     32'(hit1),     32'(tbl[i].h1));
      chk($sformatf("row%0d fwd1", i),     fwd1,          tbl[i].f1);
      chk($sformatf("row%0d hit2", i),     32'(hit2),     32'(tbl[i].h2));
      chk($sformatf("row%0d fwd2", i),     fwd2,          tbl[i].f2);
      chk($sformatf("row%0d count", i),    32'(count),    32'(tbl[i].cnt));
      chk($sformatf("row%0d pc_drop", i),  32'(pc_drop),  32'(tbl[i].pc));
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; wb_stall = 1'b0; src1 = '0; src2 = '0;

    // Fill while stalled; the fifth write waits for space, with no bypass
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_dest = 4'(i); in_data = 32'h100 + 32'(i);
      tick();
    end
    in_dest = 4'd5; in_data = 32'h105;
    #1;
    chk("full count", 32'(count), 4);
    chk("full in_ready", 32'(in_ready), 0);
    chk("full wb_en", 32'(wb_en), 0);
    tick();
    chk("full hold count", 32'(count), 4);
    wb_stall = 1'b0;
    #1;
    chk("drain1 wb_en", 32'(wb_en), 1);
    chk("drain1 wb_dest", 32'(wb_dest), 1);
    chk("drain1 in_ready", 32'(in_ready), 0);
    tick();
    chk("drain2 count", 32'(count), 3);
    chk("drain2 in_ready", 32'(in_ready), 1);
    chk("drain2 wb_dest", 32'(wb_dest), 2);
    tick();
    in_valid = 1'b0;
    chk("drain3 count", 32'(count), 3);
    for (int i = 3; i <= 5; i++) begin
      chk($sformatf("drain order %0d wb_en", i), 32'(wb_en), 1);
      chk($sformatf("drain order %0d wb_dest", i), 32'(wb_dest), 32'(i));
      chk($sformatf("drain order %0d wb_data", i), wb_data, 32'h100 + 32'(i));
      tick();
    end
    chk("drained count", 32'(count), 0);
    chk("drained wb_en", 32'(wb_en), 0);

    // Back-to-back enqueue with continuous dequeue, wrapping the pointers
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_dest = 4'(i + 1); in_data = 32'h200 + 32'(i);
      #1;
      if (i > 0) begin
        chk($sformatf("stream%0d wb_en", i), 32'(wb_en), 1);
        chk($sformatf("stream%0d wb_dest", i), 32'(wb_dest), 32'(i));
        chk($sformatf("stream%0d wb_data", i), wb_data, 32'h200 + 32'(i - 1));
        chk($sformatf("stream%0d count", i), 32'(count), 1);
      end
      tick();
    end
    in_valid = 1'b0;
    #2;
    chk("pre-rst wb_dest", 32'(wb_dest), 10);
    // Asynchronous reset in the middle of the cycle
    rst = 1'b1;
    #1;
    chk("async rst wb_en", 32'(wb_en), 0);
    chk("async rst count", 32'(count), 0);
    chk("async rst wb_dest", 32'(wb_dest), 0);
    chk("async rst wb_data", wb_data, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_dest = 4'd6; in_data = 32'h66;
    tick();
    in_valid = 1'b0;
    chk("post-rst wb_en", 32'(wb_en), 1);
    chk("post-rst wb_dest", 32'(wb_dest), 6);
    chk("post-rst wb_data", wb_data, 32'h66);
    tick();
    chk("post-rst final count", 32'(count), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Run bound
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1);
  end
endmodule
